// File: rtl/axis_unpacker_pkg.sv
// Shared types for the wide-to-narrow AXI-Stream unpacker.
// The FSM state is implied by the holding register's valid flag.
package axis_unpacker_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } unpack_state_e;

  function automatic int lane_bits(input int ratio);
    return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (valid/ready/data) shared by the stream blocks.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_unpacker.sv
// Splits each wide AXI-Stream word into RATIO narrow beats, LSB lane first,
// with a single holding register and no bubble between consecutive words.
module axis_unpacker
  import axis_unpacker_pkg::*;
#(
  parameter int RATIO = 4
) (
  input  logic clk,
  input  logic rst,
  axis_if.s    axis_sif,
  axis_if.m    axis_mif,
  input  logic invalidate
);

  localparam int W_IN  = axis_sif.TDATA_WIDTH;
  localparam int W_OUT = axis_mif.TDATA_WIDTH;
  localparam int LW    = lane_bits(RATIO);
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

  if (W_OUT <= 0 || W_IN != RATIO * W_OUT) begin : g_width_check
    $fatal(1, "axis_unpacker: W_IN must equal RATIO*W_OUT with W_OUT > 0");
  end

  logic [W_IN-1:0]  data_q,  data_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    lane_q,  lane_d;
  logic [W_OUT-1:0] lane_w [RATIO];
  unpack_state_e    state;
  logic             in_hs, out_hs;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lanes
    assign lane_w[gi] = data_q[gi*W_OUT +: W_OUT];
  end

  assign state           = valid_q ? HOLD : EMPTY;
  assign axis_mif.tvalid = valid_q;
  assign axis_mif.tdata  = lane_w[lane_q];
  // A new word may enter only while the last lane is leaving, which keeps the stream gap-free.
  assign axis_sif.tready = !invalidate && (!valid_q || (lane_q == LAST && axis_mif.tready));
  assign in_hs           = axis_sif.tvalid && axis_sif.tready;
  assign out_hs          = valid_q && axis_mif.tready;

  always_comb begin
    valid_d = valid_q;
    lane_d  = lane_q;
    data_d  = data_q;
    if (invalidate) begin
      valid_d = 1'b0;
      lane_d  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_hs) begin
            data_d  = axis_sif.tdata;
            valid_d = 1'b1;
            lane_d  = '0;
          end
        end
        HOLD: begin
          if (in_hs) begin
            data_d  = axis_sif.tdata;
            valid_d = 1'b1;
            lane_d  = '0;
          end else if (out_hs) begin
            if (lane_q == LAST) begin
              valid_d = 1'b0;
              lane_d  = '0;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          lane_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      lane_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_axis_unpacker.sv
// Self-checking bench for axis_unpacker: RATIO=4 (32->8) and RATIO=3 (24->8) instances
// with a per-instance scoreboard of expected narrow beats.
module tb_axis_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv4 = 1'b0;
  logic inv3 = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.TDATA_WIDTH(32)) s4 ();
  axis_if #(.TDATA_WIDTH(8))  m4 ();
  axis_if #(.TDATA_WIDTH(24)) s3 ();
  axis_if #(.TDATA_WIDTH(8))  m3 ();

  axis_unpacker #(.RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .axis_sif(s4), .axis_mif(m4), .invalidate(inv4)
  );
  axis_unpacker #(.RATIO(3)) dut3 (
    .clk(clk), .rst(rst), .axis_sif(s3), .axis_mif(m3), .invalidate(inv3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp4[$];
  logic [7:0] exp3[$];
  logic [7:0] e4, e3;
  bit   contig4 = 1'b0, have_last4 = 1'b0, rand3 = 1'b0;
  int   last4 = 0, hs_first4 = 0, hs_cyc4 = 0;
  bit   st4_q = 1'b0, st3_q = 1'b0;
  logic [7:0] st4_d = '0, st3_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Random sink for the RATIO=3 instance; always ready otherwise.
  always @(posedge clk) begin
    #1;
    m3.tready = rand3 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop, contiguity/latency and stall stability.
  always @(negedge clk) begin
    if (m4.tvalid && m4.tready) begin
      if (exp4.size() == 0) begin
        chk("beat4_unexpected", {24'h0, m4.tdata}, 32'hFFFF_FFFF);
      end else begin
        e4 = exp4.pop_front();
        chk("beat4", {24'h0, m4.tdata}, {24'h0, e4});
      end
      if (contig4) begin
        if (have_last4) chk("beat4_contig_cycle", cyc, last4 + 1);
        else            chk("beat4_latency_cycle", cyc, hs_first4 + 1);
      end
      have_last4 = 1'b1;
      last4 = cyc;
    end
    if (m3.tvalid && m3.tready) begin
      if (exp3.size() == 0) begin
        chk("beat3_unexpected", {24'h0, m3.tdata}, 32'hFFFF_FFFF);
      end else begin
        e3 = exp3.pop_front();
        chk("beat3", {24'h0, m3.tdata}, {24'h0, e3});
      end
    end
    if (st4_q) chk("stable4", {23'h0, m4.tvalid, m4.tdata}, {23'h0, 1'b1, st4_d});
    if (st3_q) chk("stable3", {23'h0, m3.tvalid, m3.tdata}, {23'h0, 1'b1, st3_d});
    if (rand3) chk("lane3_bound", {31'h0, (int'(dut3.lane_q) > 2)}, 32'h0);
    st4_q = m4.tvalid && !m4.tready && !rst && !inv4;
    st4_d = m4.tdata;
    st3_q = m3.tvalid && !m3.tready && !rst && !inv3;
    st3_d = m3.tdata;
  end

  // Leaves tvalid high after the handshake so consecutive calls are back-to-back.
  task automatic send4(input logic [31:0] d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    s4.tdata = d;
    s4.tvalid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (s4.tready) ok = 1'b1;
      else waited++;
    end
    if (!ok) chk("send4_timeout", 32'h0, 32'h1);
    hs_cyc4 = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send3(input logic [23:0] d);
    bit ok;
    ok = 1'b0;
    s3.tdata = d;
    s3.tvalid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (s3.tready) ok = 1'b1;
    end
    if (!ok) chk("send3_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain4(input string name);
    for (int k = 0; k < 200 && exp4.size() != 0; k++) @(posedge clk);
    chk(name, exp4.size(), 0);
    #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [7:0]  l0, l1, l2, l3;
  } vec_t;

  vec_t tbl[3];
  int   w;

  initial begin
    tbl[0] = '{din: 32'h44332211, l0: 8'h11, l1: 8'h22, l2: 8'h33, l3: 8'h44};
    tbl[1] = '{din: 32'h88776655, l0: 8'h55, l1: 8'h66, l2: 8'h77, l3: 8'h88};
    tbl[2] = '{din: 32'hDEADBEEF, l0: 8'hEF, l1: 8'hBE, l2: 8'hAD, l3: 8'hDE};

    s4.tvalid = 1'b0; s4.tdata = '0; m4.tready = 1'b1;
    s3.tvalid = 1'b0; s3.tdata = '0;

    #2;
    chk("rst_m4_tvalid", {31'h0, m4.tvalid}, 32'h0);
    chk("rst_s4_tready", {31'h0, s4.tready}, 32'h1);
    chk("rst_m3_tvalid", {31'h0, m3.tvalid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back words with an always-ready sink: contiguous beats, latency 1.
    have_last4 = 1'b0;
    contig4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp4.push_back(tbl[k].l0); exp4.push_back(tbl[k].l1);
      exp4.push_back(tbl[k].l2); exp4.push_back(tbl[k].l3);
      send4(tbl[k].din, w);
      if (k == 0) hs_first4 = hs_cyc4;
      else chk("b2b_ready_on_lane3_wait", w, 3);
    end
    s4.tvalid = 1'b0;
    drain4("drain_table");
    contig4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_m4_tvalid", {31'h0, m4.tvalid}, 32'h0);

    // Sink stalls three cycles on lane 1.
    exp4.push_back(8'h11); exp4.push_back(8'h22); exp4.push_back(8'h33); exp4.push_back(8'h44);
    send4(32'h44332211, w);
    s4.tvalid = 1'b0;
    @(posedge clk); #1 m4.tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_tdata", {24'h0, m4.tdata}, 32'h22);
      chk("stall_tvalid", {31'h0, m4.tvalid}, 32'h1);
      @(posedge clk); #1;
    end
    m4.tready = 1'b1;
    drain4("drain_stall");

    // Invalidate after 0x11 has been taken; the remaining lanes are dropped.
    exp4.push_back(8'h11);
    send4(32'h44332211, w);
    s4.tvalid = 1'b0;
    @(posedge clk); #1;
    m4.tready = 1'b0;
    inv4 = 1'b1;
    @(negedge clk);
    chk("inv_s4_tready_low", {31'h0, s4.tready}, 32'h0);
    @(posedge clk); #1;
    inv4 = 1'b0;
    m4.tready = 1'b1;
    @(negedge clk);
    chk("post_inv_m4_tvalid", {31'h0, m4.tvalid}, 32'h0);
    chk("post_inv_s4_tready", {31'h0, s4.tready}, 32'h1);
    exp4.push_back(8'hAA); exp4.push_back(8'hBB); exp4.push_back(8'hCC); exp4.push_back(8'hDD);
    @(posedge clk); #1;
    send4(32'hDDCCBBAA, w);
    s4.tvalid = 1'b0;
    drain4("drain_inv");

    // Asynchronous reset in the middle of a word, after 0x22.
    exp4.push_back(8'h11); exp4.push_back(8'h22);
    send4(32'h44332211, w);
    s4.tvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_m4_tvalid", {31'h0, m4.tvalid}, 32'h0);
    chk("async_rst_s4_tready", {31'h0, s4.tready}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("post_rst_no_beats", exp4.size(), 0);

    // RATIO=3 with a randomized sink.
    rand3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp3.push_back(8'h01); exp3.push_back(8'h02); exp3.push_back(8'h03);
    end
    send3(24'h030201);
    send3(24'h030201);
    s3.tvalid = 1'b0;
    for (int k = 0; k < 300 && exp3.size() != 0; k++) @(posedge clk);
    chk("drain3", exp3.size(), 0);
    rand3 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("idle_m3_tvalid", {31'h0, m3.tvalid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
